// File: rtl/dispatch_queue.sv
// In-order dispatch FIFO: each entry targets one execution unit,
// with per-unit busy stalls, flush, overflow flag and stall counter.
module dispatch_queue #(
  parameter int DEPTH       = 16,
  parameter int INSTR_WIDTH = 32,
  parameter int NUM_UNITS   = 4,
  parameter int AF_THRESH   = 12
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         we,
  input  logic [INSTR_WIDTH-1:0]       in_instr,
  input  logic [$clog2(NUM_UNITS)-1:0] in_unit,
  input  logic                         flush,
  input  logic [NUM_UNITS-1:0]         unit_busy,
  input  logic                         global_freeze,
  output logic [NUM_UNITS-1:0]         out_valid,
  output logic [INSTR_WIDTH-1:0]       out_instr,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         empty,
  output logic                         full,
  output logic                         almost_full,
  output logic                         drop_err,
  output logic [15:0]                  hol_stall
);

  localparam int UW = $clog2(NUM_UNITS);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [UW-1:0]          unit;
    logic [INSTR_WIDTH-1:0] instr;
  } entry_t;

  entry_t         mem [DEPTH];
  entry_t         head;
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic [CW-1:0]  count_nxt;
  logic [NUM_UNITS-1:0] head_hot;
  logic           unit_ok;
  logic           blocked;
  logic           push;
  logic           pop;
  logic           reject;
  logic           hol_inc;

  assign empty       = (count == '0);
  assign full        = (count == CW'(DEPTH));
  assign almost_full = (count >= CW'(AF_THRESH));

  // Out-of-range unit ids shift out to zero: never busy, never dispatched.
  assign head     = mem[rd_ptr];
  assign head_hot = NUM_UNITS'(1) << head.unit;
  assign unit_ok  = |head_hot;
  assign blocked  = global_freeze | (|(unit_busy & head_hot));
  assign pop      = !empty && !blocked && !flush;
  assign push     = we && !full && !flush;
  assign reject   = we && full && !flush;
  assign hol_inc  = !empty && !flush && blocked;

  always_comb begin
    count_nxt = count;
    unique case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{unit: in_unit, instr: in_instr};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      out_valid <= '0;
      out_instr <= '0;
      drop_err  <= 1'b0;
      hol_stall <= '0;
    end else begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        count <= count_nxt;
      end
      out_valid <= pop ? head_hot : '0;
      if (pop && unit_ok) out_instr <= head.instr;
      if (reject || (pop && !unit_ok)) drop_err <= 1'b1;
      if (hol_inc && hol_stall != 16'hFFFF)
        hol_stall <= hol_stall + 1'b1;
    end
  end

endmodule

// File: tb/tb_dispatch_queue.sv
// Bench for dispatch_queue: directed scenarios plus random traffic
// checked every cycle against a queue-based reference model.
module tb_dispatch_queue;

  localparam int DEPTH = 16;
  localparam int IW    = 32;
  localparam int NU    = 4;
  localparam int AF    = 12;

  logic          clk = 0;
  logic          reset = 1;
  logic          we = 0;
  logic [IW-1:0] in_instr = '0;
  logic [1:0]    in_unit = '0;
  logic          flush = 0;
  logic [NU-1:0] unit_busy = '0;
  logic          global_freeze = 0;
  logic [NU-1:0] out_valid;
  logic [IW-1:0] out_instr;
  logic [4:0]    count;
  logic          empty;
  logic          full;
  logic          almost_full;
  logic          drop_err;
  logic [15:0]   hol_stall;

  dispatch_queue #(
    .DEPTH(DEPTH), .INSTR_WIDTH(IW), .NUM_UNITS(NU), .AF_THRESH(AF)
  ) dut (
    .clk(clk), .reset(reset), .we(we), .in_instr(in_instr),
    .in_unit(in_unit), .flush(flush), .unit_busy(unit_busy),
    .global_freeze(global_freeze), .out_valid(out_valid),
    .out_instr(out_instr), .count(count), .empty(empty),
    .full(full), .almost_full(almost_full), .drop_err(drop_err),
    .hol_stall(hol_stall)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          unit;
    logic [31:0] instr;
  } ent_t;

  ent_t        q[$];
  logic [3:0]  m_valid;
  logic [31:0] m_instr;
  logic        m_drop;
  int          m_hol;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_valid = '0;
    m_instr = '0;
    m_drop  = 0;
    m_hol   = 0;
  endtask

  task automatic model_edge();
    int sz;
    ent_t e;
    sz = q.size();
    m_valid = '0;
    if (flush) begin
      q.delete();
    end else begin
      if (sz > 0 && !global_freeze &&
          !(q[0].unit < NU && unit_busy[q[0].unit])) begin
        e = q.pop_front();
        if (e.unit >= NU) m_drop = 1;
        else begin
          m_valid = 4'(1 << e.unit);
          m_instr = e.instr;
        end
      end else if (sz > 0) begin
        m_hol = (m_hol == 65535) ? 65535 : m_hol + 1;
      end
      if (we) begin
        if (sz == DEPTH) m_drop = 1;
        else begin
          e.unit  = int'(in_unit);
          e.instr = in_instr;
          q.push_back(e);
        end
      end
    end
  endtask

  task automatic check_all(string tag);
    check({tag, ".valid"}, 64'(out_valid), 64'(m_valid));
    check({tag, ".instr"}, 64'(out_instr), 64'(m_instr));
    check({tag, ".count"}, 64'(count), 64'(q.size()));
    check({tag, ".empty"}, 64'(empty), 64'(q.size() == 0));
    check({tag, ".full"}, 64'(full), 64'(q.size() == DEPTH));
    check({tag, ".af"}, 64'(almost_full), 64'(q.size() >= AF));
    check({tag, ".drop"}, 64'(drop_err), 64'(m_drop));
    check({tag, ".hol"}, 64'(hol_stall), 64'(m_hol));
  endtask

  task automatic cyc(string tag, input logic w, input logic [31:0] ins,
                     input logic [1:0] u, input logic [3:0] b,
                     input logic g, input logic f);
    we = w; in_instr = ins; in_unit = u;
    unit_busy = b; global_freeze = g; flush = f;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    we = 0; in_instr = '0; in_unit = '0;
    unit_busy = '0; global_freeze = 0; flush = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset = 0;
    #1;
    model_reset();
    check_all("rst");
    @(negedge clk);
    reset = 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int maxc;
    do_reset();

    // single entry to unit 2, one-cycle latency
    cyc("s1.push", 1, 32'hA5A5_0001, 2'd2, 4'h0, 0, 0);
    cyc("s1.disp", 0, 32'h0, 2'd0, 4'h0, 0, 0);
    check("s1.onehot", 64'(out_valid), 64'h4);
    check("s1.payload", 64'(out_instr), 64'hA5A5_0001);
    check("s1.empty", 64'(empty), 64'h1);

    // head-of-line blocking by unit 0
    do_reset();
    cyc("s2.px", 1, 32'h0000_00A0, 2'd0, 4'h0, 0, 0);
    cyc("s2.py", 1, 32'h0000_00B1, 2'd1, 4'h1, 0, 0);
    for (int i = 0; i < 4; i++)
      cyc("s2.stall", 0, 32'h0, 2'd0, 4'h1, 0, 0);
    check("s2.hol5", 64'(hol_stall), 64'd5);
    check("s2.nodisp", 64'(out_valid), 64'h0);
    cyc("s2.x", 0, 32'h0, 2'd0, 4'h0, 0, 0);
    check("s2.xvalid", 64'(out_valid), 64'h1);
    cyc("s2.y", 0, 32'h0, 2'd0, 4'h0, 0, 0);
    check("s2.yvalid", 64'(out_valid), 64'h2);
    check("s2.ypay", 64'(out_instr), 64'hB1);

    // fill to full under freeze, then overflow
    do_reset();
    for (int i = 0; i < DEPTH; i++)
      cyc("s3.fill", 1, 32'(i + 100), 2'(i), 4'h0, 1, 0);
    check("s3.full", 64'(full), 64'h1);
    check("s3.count", 64'(count), 64'd16);
    cyc("s3.ovf", 1, 32'hDEAD, 2'd3, 4'h0, 1, 0);
    check("s3.ovfcnt", 64'(count), 64'd16);
    check("s3.dropset", 64'(drop_err), 64'h1);

    // streaming 40 entries, alternating units
    do_reset();
    maxc = 0;
    for (int i = 0; i < 40; i++) begin
      cyc("s4.stream", 1, 32'(i), 2'(i % 4), 4'h0, 0, 0);
      if (int'(count) > maxc) maxc = int'(count);
    end
    for (int i = 0; i < 2; i++)
      cyc("s4.drain", 0, 32'h0, 2'd0, 4'h0, 0, 0);
    check("s4.maxcnt", 64'(maxc <= 2), 64'h1);

    // flush with a simultaneous push
    do_reset();
    for (int i = 0; i < 7; i++)
      cyc("s5.fill", 1, 32'(i + 7), 2'(i), 4'h0, 1, 0);
    cyc("s5.flush", 1, 32'hBEEF, 2'd1, 4'h0, 0, 1);
    check("s5.count", 64'(count), 64'd0);
    check("s5.drop", 64'(drop_err), 64'h0);
    cyc("s5.after", 0, 32'h0, 2'd0, 4'h0, 0, 0);

    // asynchronous reset mid-stream
    do_reset();
    for (int i = 0; i < 5; i++)
      cyc("s6.fill", 1, 32'(i + 50), 2'(i), 4'h0, 1, 0);
    idle_inputs();
    #2;
    reset = 0;
    #1;
    model_reset();
    check_all("s6.async");
    @(negedge clk);
    reset = 1;
    for (int i = 0; i < 3; i++)
      cyc("s6.quiet", 0, 32'h0, 2'd0, 4'h0, 0, 0);
    cyc("s6.push", 1, 32'h0000_5151, 2'd3, 4'h0, 0, 0);
    cyc("s6.disp", 0, 32'h0, 2'd0, 4'h0, 0, 0);

    // random traffic
    do_reset();
    for (int i = 0; i < 500; i++) begin
      logic [3:0] b;
      for (int k = 0; k < NU; k++) b[k] = ($urandom_range(3) == 0);
      cyc("rnd", $urandom_range(2) != 0, $urandom, 2'($urandom),
          b, $urandom_range(9) == 0, $urandom_range(40) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dispatch_queue.md
Name: dispatch_queue

Overview:
- Parametrised successor to the single global-freeze instruction queue: an in-order FIFO that dispatches each entry to one of NUM_UNITS execution units (DMA, dcache, math, ...).
- Each unit stalls independently through its own busy line, replacing the single design-wide freeze.
- Sits between the control unit (push side) and the unit pipelines (dispatch side).
- Adds occupancy reporting, almost-full, synchronous flush, sticky overflow error and a head-of-line stall counter.

Parameters:
- DEPTH, 16, number of entries; power of 2, minimum 2.
- INSTR_WIDTH, 32, payload width in bits.
- NUM_UNITS, 4, number of dispatch targets; minimum 2.
- AF_THRESH, 12, almost_full asserts when count >= AF_THRESH; range 1..DEPTH.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- we  in  1  push request.
- in_instr  in  INSTR_WIDTH  payload to push.
- in_unit  in  $clog2(NUM_UNITS)  target unit of the pushed entry.
- flush  in  1  synchronous clear of all entries.
- unit_busy  in  NUM_UNITS  bit u high means unit u cannot accept this cycle.
- global_freeze  in  1  blocks all dispatch.
- out_valid  out  NUM_UNITS  one-hot, registered; bit u means out_instr is dispatched to unit u this cycle.
- out_instr  out  INSTR_WIDTH  registered payload.
- count  out  $clog2(DEPTH)+1  current occupancy.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_full  out  1  count >= AF_THRESH.
- drop_err  out  1  sticky: a push was rejected.
- hol_stall  out  16  saturating count of cycles the head entry was blocked.

Behaviour:
- Reset (async, low):
  - Pointers, count, out_valid, out_instr, drop_err and hol_stall clear to 0.
  - empty = 1; full = 0; almost_full = 0.
  - Reset mid-dispatch discards all entries; no out_valid pulse follows.
- Storage:
  - Entries are {in_unit, in_instr}.
  - Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - count tracks occupancy exactly.
- Push:
  - Accepted at a rising edge when we = 1, full = 0 and flush = 0.
  - we = 1 while full = 1 is rejected, even if a pop happens the same cycle; drop_err sets and holds until reset.
- Dispatch (pop):
  - Condition at an edge: !empty & !global_freeze & !unit_busy[head_unit] & !flush.
  - When true: head pops; out_valid <= onehot(head_unit); out_instr <= head payload.
  - Otherwise out_valid <= 0 and out_instr holds its last value.
  - At most one dispatch per cycle; strict program order. A blocked head blocks all younger entries, including those for idle units.
- Latency:
  - An entry pushed at edge E into an empty queue can drive out_valid at edge E+1 at the earliest. No combinational bypass.
  - Back-to-back dispatch gives one entry per cycle while targets are free.
- Simultaneous push and pop when not full: both take effect; count is unchanged.
- hol_stall:
  - Increments by 1 on each edge where !empty and the dispatch condition is false due to global_freeze or unit_busy.
  - Saturates at 16'hFFFF.
  - Never cleared by flush; cleared only by reset.
- Flush:
  - Priority over push and pop in the same cycle: pointers and count go to 0 and out_valid goes to 0 at that edge.
  - A push in the flush cycle is discarded without setting drop_err.
- in_unit >= NUM_UNITS: the entry is dropped at dispatch time (pops, no out_valid) and drop_err sets.
- All outputs are registered or decoded from registered state only; no combinational path from inputs to outputs.

Test Plan:
- Push A (unit 2) into an empty queue at edge 1, all units idle → out_valid = 4'b0100 and out_instr = A at edge 2; empty = 1 afterwards.
- Push X (unit 0) then Y (unit 1); hold unit_busy[0] = 1 for 5 cycles → no dispatch of Y, hol_stall = 5; release → X then Y on consecutive cycles.
- Push 16 entries with global_freeze = 1 → full = 1, count = 16, almost_full from the 12th push; a 17th push with a simultaneous pop attempt leaves count = 16 and sets drop_err.
- Push and dispatch 40 entries continuously with alternating units → in-order payloads 0..39, correct one-hot each cycle, pointers wrap, count never exceeds 2.
- Queue holds 7 entries; assert flush with we = 1 → next cycle count = 0, empty = 1, out_valid = 0, drop_err = 0.
- Assert reset low asynchronously mid-stream with 5 entries → outputs go to reset values immediately; no out_valid after reset release until a new push.
